// File: rtl/mmio_cmd_fifo_bank.sv
// Bank of NUM_CH memory-mapped command FIFOs: CPU stores push words, each channel
// drains to its accelerator over valid/ready, with per-channel STATUS/CTRL registers.
module mmio_cmd_fifo_bank #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned DATA_W   = 32,
   parameter logic [3:0]  BASE_NIB = 4'h8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata,
   output logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_ready,
   output logic                     ovf_any
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [4:0]  NUM_CH_W = 5'(NUM_CH);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   logic       hit;
   logic       acc;
   logic [3:0] ch_sel;
   logic [1:0] reg_sel;
   logic       ch_ok;
   logic       data_wr;
   logic       ctrl_wr;
   logic       status_rd;

   logic [31:0]       status_w [NUM_CH];
   logic [31:0]       rd_word;
   logic [NUM_CH-1:0] ovf_vec;

   logic unused_bits;
   assign unused_bits = ^{addr[27:8], addr[1:0], wdata};

   assign hit       = (addr[31:28] == BASE_NIB);
   assign acc       = ~stall & hit;
   assign ch_sel    = addr[7:4];
   assign reg_sel   = addr[3:2];
   assign ch_ok     = ({1'b0, ch_sel} < NUM_CH_W);
   assign data_wr   = acc & wr_en & ch_ok & (reg_sel == REG_DATA);
   assign ctrl_wr   = acc & wr_en & ch_ok & (reg_sel == REG_CTRL);
   assign status_rd = ch_ok & (reg_sel == REG_STATUS);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [AW-1:0]     wr_ptr;
      logic [AW-1:0]     rd_ptr;
      logic [CW-1:0]     count;
      logic              ovf_r;
      logic              sel;
      logic              push_req;
      logic              flush;
      logic              clr_ovf;
      logic              full;
      logic              empty;
      logic              pop;
      logic              push_ok;
      logic              ovf_set;

      assign sel      = (ch_sel == 4'(g));
      assign push_req = data_wr & sel;
      assign flush    = ctrl_wr & sel & wdata[0];
      assign clr_ovf  = ctrl_wr & sel & wdata[1];
      assign full     = (count == CW'(DEPTH));
      assign empty    = (count == '0);
      // Flush overrides a same-cycle pop; a full channel still accepts when it pops.
      assign pop      = ~empty & ch_ready[g] & ~flush;
      assign push_ok  = push_req & (~full | pop);
      assign ovf_set  = push_req & full & ~pop;

      always_ff @(posedge clk) begin
         if (push_ok) mem[wr_ptr] <= wdata[DATA_W-1:0];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_r  <= 1'b0;
         end else begin
            if (flush) begin
               wr_ptr <= '0;
               rd_ptr <= '0;
               count  <= '0;
            end else begin
               if (push_ok) wr_ptr <= wr_ptr + AW'(1);
               if (pop)     rd_ptr <= rd_ptr + AW'(1);
               count <= count + CW'(push_ok) - CW'(pop);
            end
            if (clr_ovf)      ovf_r <= 1'b0;
            else if (ovf_set) ovf_r <= 1'b1;
         end
      end

      assign ch_valid[g]                  = ~empty;
      assign ch_data[g*DATA_W +: DATA_W]  = mem[rd_ptr];
      assign ovf_vec[g]                   = ovf_r;
      assign status_w[g] = {16'b0, 8'(count), 5'b0, ovf_r, full, empty};
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (status_rd && (ch_sel == 4'(i))) rd_word = status_w[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdata <= '0;
      else if (acc & rd_en) rdata <= rd_word;
   end

   assign ovf_any = |ovf_vec;

endmodule

// File: tb/tb_mmio_cmd_fifo_bank.sv
// Directed bench for mmio_cmd_fifo_bank: vector table for decode/stall/handshake,
// hand sequences for overflow, full push+pop, flush and async reset.
module tb_mmio_cmd_fifo_bank;

   localparam int NUM_CH = 4;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 32;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     stall;
   logic                     wr_en;
   logic                     rd_en;
   logic [31:0]              addr;
   logic [31:0]              wdata;
   logic [31:0]              rdata;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        ch_ready;
   logic                     ovf_any;

   int n_checks = 0;
   int n_fail   = 0;

   mmio_cmd_fifo_bank #(
      .NUM_CH  (NUM_CH),
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .BASE_NIB(4'h8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .wr_en   (wr_en),
      .rd_en   (rd_en),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .ch_valid(ch_valid),
      .ch_data (ch_data),
      .ch_ready(ch_ready),
      .ovf_any (ovf_any)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic        stl;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  rdy;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_valid;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs [17];

   function automatic logic [31:0] reg_addr(input int ch, input int r);
      return 32'h8000_0000 | (32'(ch) << 4) | (32'(r) << 2);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input int ch, input int r, input logic [31:0] d);
      stall = 1'b0; rd_en = 1'b0; wr_en = 1'b1;
      addr  = reg_addr(ch, r);
      wdata = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic status_chk(input int ch, input logic [31:0] exp, input string name);
      stall = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
      addr  = reg_addr(ch, 1);
      cyc();
      rd_en = 1'b0;
      chk(name, rdata, exp);
   endtask

   task automatic drain_chk(input int ch, input logic [31:0] exp [], input string name);
      ch_ready[ch] = 1'b1;
      foreach (exp[k]) begin
         chk({name, "_valid"}, 32'(ch_valid[ch]), 32'd1);
         chk({name, "_data"}, ch_data[ch*DATA_W +: DATA_W], exp[k]);
         cyc();
      end
      ch_ready[ch] = 1'b0;
      chk({name, "_empty"}, 32'(ch_valid[ch]), 32'd0);
   endtask

   initial begin
      logic [31:0] exp_q [];

      //        wr    rd    stl   addr           wdata   rdy      rdata        valid    ovf
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0,  4'b0000, 32'h0000_0001, 4'b0000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h55, 4'b0001, 32'h0000_0001, 4'b0001, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0,  4'b0001, 32'h0000_0001, 4'b0000, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h8000_0030, 32'h33, 4'b0000, 32'h0000_0001, 4'b1000, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h8000_0030, 32'h34, 4'b0000, 32'h0000_0001, 4'b1000, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h77, 4'b1000, 32'h0000_0001, 4'b1000, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h8000_0034, 32'h0,  4'b0000, 32'h0000_0001, 4'b1000, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0034, 32'h0,  4'b0000, 32'h0000_0100, 4'b1000, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0,  4'b1000, 32'h0000_0001, 4'b0000, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h8000_0054, 32'h0,  4'b0000, 32'h0000_0000, 4'b0000, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h8000_0034, 32'h0,  4'b0000, 32'h0000_0001, 4'b0000, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h8000_000C, 32'h0,  4'b0000, 32'h0000_0000, 4'b0000, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h9000_0004, 32'h0,  4'b0000, 32'h0000_0000, 4'b0000, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 32'h9000_0000, 32'hEE, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h8000_000C, 32'h1,  4'b0000, 32'h0000_0000, 4'b0000, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h8000_0050, 32'h9,  4'b0000, 32'h0000_0000, 4'b0000, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0,  4'b0000, 32'h0000_0001, 4'b0000, 1'b0};

      rst = 1'b0; stall = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      addr = '0; wdata = '0; ch_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_valid", 32'(ch_valid), 32'h0);
      chk("reset_ovf", 32'(ovf_any), 32'h0);
      #2 rst = 1'b1;
      cyc();

      for (int i = 0; i < 17; i++) begin
         wr_en = vecs[i].wr; rd_en = vecs[i].rd; stall = vecs[i].stl;
         addr = vecs[i].a; wdata = vecs[i].d; ch_ready = vecs[i].rdy;
         cyc();
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_valid", i), 32'(ch_valid), 32'(vecs[i].exp_valid));
         chk($sformatf("vec%0d_ovf", i), 32'(ovf_any), 32'(vecs[i].exp_ovf));
      end
      wr_en = 1'b0; rd_en = 1'b0; stall = 1'b0; ch_ready = '0;

      // Overflow on ch1: nine stores, ninth dropped.
      for (int k = 0; k < 9; k++) store(1, 0, 32'h10 + 32'(k));
      status_chk(1, 32'h0000_0806, "ovf_status");
      chk("ovf_any_set", 32'(ovf_any), 32'd1);
      exp_q = new[8];
      foreach (exp_q[k]) exp_q[k] = 32'h10 + 32'(k);
      drain_chk(1, exp_q, "ovf_drain");

      // Flush + clear-overflow beats a same-cycle pop.
      for (int k = 0; k < 5; k++) store(1, 0, 32'h40 + 32'(k));
      status_chk(1, 32'h0000_0504, "pre_flush_status");
      ch_ready[1] = 1'b1;
      store(1, 2, 32'h3);
      ch_ready[1] = 1'b0;
      chk("flush_valid", 32'(ch_valid[1]), 32'd0);
      chk("flush_ovf", 32'(ovf_any), 32'd0);
      status_chk(1, 32'h0000_0001, "post_flush_status");

      // Full channel: push and pop in the same cycle.
      for (int k = 0; k < 8; k++) store(2, 0, 32'h20 + 32'(k));
      ch_ready[2] = 1'b1;
      store(2, 0, 32'hAA);
      ch_ready[2] = 1'b0;
      status_chk(2, 32'h0000_0802, "full_pushpop_status");
      chk("full_pushpop_ovf", 32'(ovf_any), 32'd0);
      exp_q = new[8];
      foreach (exp_q[k]) exp_q[k] = (k < 7) ? 32'h21 + 32'(k) : 32'hAA;
      drain_chk(2, exp_q, "full_pushpop_drain");

      // Asynchronous reset mid-drain.
      for (int k = 0; k < 3; k++) store(0, 0, 32'h60 + 32'(k));
      for (int k = 0; k < 9; k++) store(3, 0, 32'h70 + 32'(k));
      status_chk(3, 32'h0000_0806, "pre_reset_status");
      ch_ready[0] = 1'b1;
      cyc();
      chk("mid_drain_valid", 32'(ch_valid), 32'h9);
      #2 rst = 1'b0;
      #1;
      chk("async_reset_valid", 32'(ch_valid), 32'h0);
      chk("async_reset_ovf", 32'(ovf_any), 32'h0);
      chk("async_reset_rdata", rdata, 32'h0);
      ch_ready = '0;
      #3 rst = 1'b1;
      cyc();
      status_chk(0, 32'h0000_0001, "post_reset_status0");
      status_chk(3, 32'h0000_0001, "post_reset_status3");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
